multicycle_controller: RTL and testbench

- Moore-FSM sequencer for the multi-cycle MIPS datapath: one shared memory, one ALU, IR, and register file reused across cycles.
- Decodes the same opcode set and ALUOp encoding as the single-cycle control unit.
- Drives per-cycle strobes and mux selects.
- Waits on a memory-ready handshake, and halts on illegal opcodes.

---
 rtl/multicycle_controller_if.sv | 43 ++++
 rtl/multicycle_controller.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// master = sequencer, slave = datapath/memory side.
interface multicycle_controller_if;
  logic       run;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  run, opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d,
    output mem_read, mem_write, ir_write,
    output reg_dst, mem_to_reg, reg_write,
    output alu_src_a, alu_src_b, alu_op,
    output pc_source, instr_done,
    output illegal_op, state
  );

  modport slave (
    output run, opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d,
    input  mem_read, mem_write, ir_write,
    input  reg_dst, mem_to_reg, reg_write,
    input  alu_src_a, alu_src_b, alu_op,
    input  pc_source, instr_done,
    input  illegal_op, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencer for the multi-cycle MIPS datapath.
// Outputs decode from state_q/op_q; only FETCH/MEM_WRITE look at mem_ready.
module multicycle_controller #(
  parameter logic [5:0] OP_R    = 6'd0,
  parameter logic [5:0] OP_LW   = 6'd35,
  parameter logic [5:0] OP_SW   = 6'd43,
  parameter logic [5:0] OP_BEQ  = 6'd4,
  parameter logic [5:0] OP_BNE  = 6'd5,
  parameter logic [5:0] OP_ADDI = 6'h8,
  parameter logic [5:0] OP_ANDI = 6'hC,
  parameter logic [5:0] OP_ORI  = 6'hD
) (
  input logic clk,
  input logic rst_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    IMM_EXEC  = 4'd10,
    IMM_WB    = 4'd11,
    TRAP      = 4'd12
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       ill_q, ill_d;

  logic is_mem, is_r, is_br, is_imm;

  always_comb begin
    is_mem = (bus.opcode == OP_LW)  || (bus.opcode == OP_SW);
    is_r   = (bus.opcode == OP_R);
    is_br  = (bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE);
    is_imm = (bus.opcode == OP_ADDI) ||
             (bus.opcode == OP_ANDI) ||
             (bus.opcode == OP_ORI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 6'd0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ill_d   = ill_q;
    unique case (state_q)
      IDLE:      if (bus.run) state_d = FETCH;
      FETCH:     if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        op_d = bus.opcode;
        unique case (1'b1)
          is_mem:  state_d = MEM_ADDR;
          is_r:    state_d = R_EXEC;
          is_br:   state_d = BRANCH;
          is_imm:  state_d = IMM_EXEC;
          default: state_d = TRAP;
        endcase
      end
      MEM_ADDR:  state_d = (op_q == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (bus.mem_ready) state_d = MEM_WB;
      MEM_WB:    state_d = FETCH;
      MEM_WRITE: if (bus.mem_ready) state_d = FETCH;
      R_EXEC:    state_d = R_WB;
      R_WB:      state_d = FETCH;
      BRANCH:    state_d = FETCH;
      IMM_EXEC:  state_d = IMM_WB;
      IMM_WB:    state_d = FETCH;
      TRAP:      state_d = TRAP;
      default:   state_d = TRAP;
    endcase
    // sticky flag goes up on the same edge that enters TRAP
    if (state_d == TRAP) ill_d = 1'b1;
  end

  logic       pc_write, pc_write_cond, i_or_d;
  logic       mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, instr_done;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = bus.mem_ready;
        ir_write  = bus.mem_ready;
      end
      DECODE: alu_src_b = 2'b11;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      // strobe held for the whole dwell; memory commits on mem_ready
      MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = bus.mem_ready;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = (op_q == OP_BNE) ? 3'b111 : 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        unique case (1'b1)
          op_q == OP_ANDI: alu_op = 3'b011;
          op_q == OP_ORI:  alu_op = 3'b100;
          default:         alu_op = 3'b000;
        endcase
      end
      IMM_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.i_or_d        = i_or_d;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.reg_dst       = reg_dst;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.pc_source     = pc_source;
  assign bus.instr_done    = instr_done;
  assign bus.illegal_op    = ill_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected output
// vectors are queued on drive and popped at the falling edge.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  string cur = "";
  logic [5:0] mop = 6'd0;
  logic [22:0] sb[$];

  // reference outputs from the state table, packed like got_vec
  function automatic logic [22:0] model(
    input logic [3:0] s, input logic [5:0] op,
    input logic mr, input logic ill);
    logic pw, pwc, iod, mrd, mwr, irw, rdst, m2r, rw, sa, dn;
    logic [1:0] sb_, ps;
    logic [2:0] ao;
    {pw, pwc, iod, mrd, mwr, irw, rdst, m2r, rw, sa, dn} = '0;
    sb_ = 2'b00; ps = 2'b00; ao = 3'b000;
    case (s)
      4'd1: begin mrd = 1; sb_ = 2'b01; pw = mr; irw = mr; end
      4'd2: sb_ = 2'b11;
      4'd3: begin sa = 1; sb_ = 2'b10; end
      4'd4: begin mrd = 1; iod = 1; end
      4'd5: begin m2r = 1; rw = 1; dn = 1; end
      4'd6: begin mwr = 1; iod = 1; dn = mr; end
      4'd7: begin sa = 1; ao = 3'b010; end
      4'd8: begin rdst = 1; rw = 1; dn = 1; end
      4'd9: begin
        sa = 1; pwc = 1; ps = 2'b01; dn = 1;
        ao = (op == 6'd5) ? 3'b111 : 3'b001;
      end
      4'd10: begin
        sa = 1; sb_ = 2'b10;
        ao = (op == 6'hC) ? 3'b011 :
             (op == 6'hD) ? 3'b100 : 3'b000;
      end
      4'd11: begin rw = 1; dn = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, rdst, m2r, rw,
            sa, sb_, ao, ps, dn, ill, s};
  endfunction

  function automatic logic [22:0] got_vec();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d,
            bus.mem_read, bus.mem_write, bus.ir_write,
            bus.reg_dst, bus.mem_to_reg, bus.reg_write,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_source, bus.instr_done, bus.illegal_op,
            bus.state};
  endfunction

  // called just after a rising edge; ends just after the next one
  task automatic cyc(input logic r, input logic [5:0] opc,
                     input logic mr, input logic [3:0] es,
                     input logic ei);
    logic [22:0] got, exp;
    bus.run = r;
    bus.opcode = opc;
    bus.mem_ready = mr;
    sb.push_back(model(es, mop, mr, ei));
    @(negedge clk);
    got = got_vec();
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got=%h exp=%h (state got=%0d exp=%0d)",
               cur, $time, got, exp, got[3:0], exp[3:0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cur = "reset";
    rst_n = 1'b0;
    cyc(1'b0, 6'h0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;
    repeat (5) cyc(1'b0, 6'h3F, 1'b1, 4'd0, 1'b0);
    cur = "run_pulse";
    cyc(1'b1, 6'h3F, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 6'h3F, 1'b0, 4'd1, 1'b0);
    cyc(1'b0, 6'h3F, 1'b0, 4'd1, 1'b0);
  endtask

  task automatic test_rtype();
    cur = "rtype";
    mop = 6'd0;
    cyc(1'b1, 6'h3F, 1'b1, 4'd1, 1'b0);
    cyc(1'b1, 6'd0, 1'b1, 4'd2, 1'b0);
    cyc(1'b1, 6'h3F, 1'b1, 4'd7, 1'b0);
    cyc(1'b1, 6'h3F, 1'b1, 4'd8, 1'b0);
  endtask

  task automatic test_lw();
    cur = "lw";
    mop = 6'd35;
    cyc(1'b0, 6'h3F, 1'b1, 4'd1, 1'b0);
    cyc(1'b0, 6'd35, 1'b1, 4'd2, 1'b0);
    cyc(1'b0, 6'd43, 1'b1, 4'd3, 1'b0);
    cyc(1'b0, 6'h3F, 1'b0, 4'd4, 1'b0);
    cyc(1'b0, 6'h3F, 1'b0, 4'd4, 1'b0);
    cyc(1'b0, 6'h3F, 1'b1, 4'd4, 1'b0);
    cyc(1'b0, 6'h3F, 1'b1, 4'd5, 1'b0);
  endtask

  task automatic test_sw();
    cur = "sw";
    mop = 6'd43;
    cyc(1'b0, 6'h3F, 1'b0, 4'd1, 1'b0);
    cyc(1'b0, 6'h3F, 1'b1, 4'd1, 1'b0);
    cyc(1'b0, 6'd43, 1'b1, 4'd2, 1'b0);
    cyc(1'b0, 6'd35, 1'b1, 4'd3, 1'b0);
    cyc(1'b0, 6'h3F, 1'b0, 4'd6, 1'b0);
    cyc(1'b0, 6'h3F, 1'b0, 4'd6, 1'b0);
    cyc(1'b0, 6'h3F, 1'b1, 4'd6, 1'b0);
  endtask

  task automatic test_branch();
    logic [5:0] ops[2];
    ops = '{6'd4, 6'd5};
    cur = "branch";
    foreach (ops[i]) begin
      mop = ops[i];
      cyc(1'b0, 6'h3F, 1'b1, 4'd1, 1'b0);
      cyc(1'b0, ops[i], 1'b1, 4'd2, 1'b0);
      cyc(1'b0, ~ops[i], 1'b1, 4'd9, 1'b0);
    end
  endtask

  task automatic test_imm();
    logic [5:0] ops[3];
    ops = '{6'h8, 6'hC, 6'hD};
    cur = "imm";
    foreach (ops[i]) begin
      mop = ops[i];
      cyc(1'b0, 6'h3F, 1'b1, 4'd1, 1'b0);
      cyc(1'b0, ops[i], 1'b1, 4'd2, 1'b0);
      cyc(1'b0, 6'd5, 1'b1, 4'd10, 1'b0);
      cyc(1'b0, 6'h3F, 1'b1, 4'd11, 1'b0);
    end
  endtask

  task automatic test_trap();
    cur = "trap";
    mop = 6'h3F;
    cyc(1'b0, 6'h3F, 1'b1, 4'd1, 1'b0);
    cyc(1'b0, 6'h3F, 1'b1, 4'd2, 1'b0);
    for (int i = 0; i < 12; i++)
      cyc(1'b1, 6'($urandom), 1'($urandom), 4'd12, 1'b1);
    cur = "trap_reset";
    rst_n = 1'b0;
    cyc(1'b1, 6'h0, 1'b1, 4'd0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b1, 6'h3F, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_sw_reset();
    cur = "sw_reset";
    mop = 6'd43;
    cyc(1'b0, 6'h3F, 1'b1, 4'd1, 1'b0);
    cyc(1'b0, 6'd43, 1'b1, 4'd2, 1'b0);
    cyc(1'b0, 6'h3F, 1'b1, 4'd3, 1'b0);
    bus.mem_ready = 1'b0;
    total++;
    if (bus.mem_write !== 1'b1) begin
      bad++;
      $display("FAIL sw_hold: mem_write got=%b exp=1", bus.mem_write);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.mem_write !== 1'b0 || bus.state !== 4'd0 ||
        bus.instr_done !== 1'b0) begin
      bad++;
      $display("FAIL sw_async: mem_write=%b state=%0d done=%b exp 0/0/0",
               bus.mem_write, bus.state, bus.instr_done);
    end
    cyc(1'b0, 6'h3F, 1'b1, 4'd0, 1'b0);
    rst_n = 1'b1;
    cur = "recover";
    cyc(1'b1, 6'h3F, 1'b1, 4'd0, 1'b0);
    test_rtype();
    cur = "after_r";
    cyc(1'b0, 6'h3F, 1'b1, 4'd1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.run = 1'b0;
    bus.opcode = 6'd0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_branch();
    test_imm();
    test_trap();
    test_sw_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
